// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the FIFO read streamer
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 2-entry order-preserving buffer, head register drives the output
module fifo_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = push_data;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        // Full: the issue rule only allows a push here together with a pop.
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - read-side master draining a parity FIFO onto a valid/ready stream
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cnt_clr,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_par_err,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_err,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  proto_err,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic                 infl_q, infl_d;
  logic                 proto_err_q, proto_err_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [1:0]           occ;
  logic [DATA_WIDTH:0]  head;
  logic                 pop;
  logic                 room;

  fifo_skid_buf #(.W(DATA_WIDTH + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data ({fifo_par_err, fifo_rd_data}),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[DATA_WIDTH-1:0];
  assign m_err   = head[DATA_WIDTH];
  assign pop     = m_valid & m_ready;

  // Count the word already in flight so a slot is reserved before its data returns.
  assign room       = ({1'b0, occ} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign fifo_rd_en = ~rst & en & ~fifo_empty & (state_q != ST_DRAIN) & room;

  always_comb begin
    state_d     = state_q;
    infl_d      = fifo_rd_en;
    proto_err_d = proto_err_q | fifo_underflow;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = ((occ != 2'd0) || infl_q) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if ((occ == 2'd0) && !infl_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cnt_clr) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (pop) begin
      if (!(&word_cnt_q))         word_cnt_d = word_cnt_q + CNT_ONE;
      if (m_err && !(&err_cnt_q)) err_cnt_d  = err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      infl_q      <= 1'b0;
      proto_err_q <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      infl_q      <= infl_d;
      proto_err_q <= proto_err_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign proto_err = proto_err_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - scoreboard bench for fifo_rd_streamer
module tb_fifo_rd_streamer;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, cnt_clr = 1'b0, m_ready = 1'b0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_par_err = 1'b0, fifo_empty = 1'b1, uf_model = 1'b0, uf_inj = 1'b0;
  logic       fifo_underflow;
  assign fifo_underflow = uf_model | uf_inj;

  logic        fifo_rd_en, m_valid, m_err, busy, proto_err;
  logic [7:0]  m_data;
  logic [15:0] word_cnt, err_cnt;
  logic        rd_en2, m_valid2, m_err2, busy2, proto_err2;
  logic [7:0]  m_data2;
  logic [1:0]  word_cnt2, err_cnt2;

  fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_par_err(fifo_par_err), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_data(m_data), .m_err(m_err), .m_ready(m_ready),
    .busy(busy), .proto_err(proto_err), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr),
    .fifo_rd_en(rd_en2), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_par_err(fifo_par_err), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid2), .m_data(m_data2), .m_err(m_err2), .m_ready(m_ready),
    .busy(busy2), .proto_err(proto_err2), .word_cnt(word_cnt2), .err_cnt(err_cnt2)
  );

  // FIFO model: 1-cycle read latency, stored parity flag returned with the word.
  logic       ld_valid = 1'b0, ld_err = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic [8:0] fq[$];
  int         model_pops = 0;

  always @(posedge clk) begin
    logic [8:0] w;
    uf_model <= fifo_rd_en && (fq.size() == 0);
    if (fifo_rd_en && fq.size() > 0) begin
      w = fq.pop_front();
      fifo_rd_data <= w[7:0];
      fifo_par_err <= w[8];
      model_pops   <= model_pops + 1;
    end
    if (ld_valid) fq.push_back({ld_err, ld_data});
    fifo_empty <= (fq.size() == 0);
  end

  logic [8:0] exp_q[$];
  int checks = 0, passed = 0, fails = 0;
  int cyc = 0, delivered = 0, first_rd = -1, first_v = -1, first_pop = -1, last_pop = -1;
  int wc = 0, ec = 0, wc2 = 0, ec2 = 0;
  int lost;
  logic hold_pend = 1'b0, occ_bad = 1'b0, lockstep_bad = 1'b0;
  logic [8:0] hold_word = '0;
  logic [7:0] vals[5] = '{8'd20, 8'd32, 8'd45, 8'd55, 8'd80};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycle(input logic en_v, input logic rdy_v, input logic clr_v);
    logic       pop;
    logic [8:0] e;
    @(posedge clk); #1;
    en = en_v; m_ready = rdy_v; cnt_clr = clr_v;
    @(negedge clk);
    cyc++;
    if (hold_pend) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_word", {m_err, m_data}, hold_word);
    end
    if (dut.occ > 2'd2) occ_bad = 1'b1;
    if ({rd_en2, m_valid2, m_data2, m_err2, busy2, proto_err2} !==
        {fifo_rd_en, m_valid, m_data, m_err, busy, proto_err}) lockstep_bad = 1'b1;
    if (fifo_rd_en && first_rd < 0) first_rd = cyc;
    if (m_valid && first_v < 0) first_v = cyc;
    pop = m_valid && m_ready;
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("dup_word", {m_err, m_data}, 9'h1ff);
      end else begin
        e = exp_q.pop_front();
        chk("word", {m_err, m_data}, e);
      end
      delivered++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    hold_pend = m_valid && !m_ready;
    hold_word = {m_err, m_data};
    if (clr_v) begin
      wc = 0; ec = 0; wc2 = 0; ec2 = 0;
    end else if (pop) begin
      if (wc < 65535) wc++;
      if (wc2 < 3) wc2++;
      if (m_err && ec < 65535) ec++;
      if (m_err && ec2 < 3) ec2++;
    end
  endtask

  task automatic check_cnts(input string t);
    cycle(en, 1'b0, 1'b0);
    chk({t, "_word_cnt"}, word_cnt, wc);
    chk({t, "_err_cnt"}, err_cnt, ec);
    chk({t, "_word_cnt2"}, word_cnt2, wc2);
    chk({t, "_err_cnt2"}, err_cnt2, ec2);
  endtask

  task automatic load(input logic [7:0] d, input logic e);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_data = d; ld_err = e;
    exp_q.push_back({e, d});
  endtask

  task automatic load_done();
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wc = 0; ec = 0; wc2 = 0; ec2 = 0;
    hold_pend = 1'b0;
    lost = model_pops - delivered;
    delivered = model_pops;
    for (int i = 0; i < lost; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic start_test();
    first_rd = -1; first_v = -1; first_pop = -1; last_pop = -1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Full-throughput stream
    for (int i = 0; i < 5; i++) load(vals[i], 1'b0);
    load_done();
    start_test();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b1, 1'b1, 1'b0);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_latency", first_v - first_rd, 2);
    chk("t1_back_to_back", last_pop - first_pop, 4);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check_cnts("t1");
    chk("t1_word_cnt_5", word_cnt, 5);
    chk("t1_word_cnt2_sat", word_cnt2, 3);
    cycle(1'b0, 1'b0, 1'b1);
    check_cnts("t1_clr");

    // Backpressure 1,0,0 with a clear landing on an accepting cycle
    for (int i = 0; i < 5; i++) load(vals[i], 1'b0);
    load_done();
    start_test();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle(1'b1, (i % 3) == 0, i == 3);
    chk("t2_drained", exp_q.size(), 0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    chk("t2_occ_bound", occ_bad, 0);
    check_cnts("t2");
    cycle(1'b0, 1'b0, 1'b1);

    // Parity error on the third word
    for (int i = 0; i < 5; i++) load(vals[i], i == 2);
    load_done();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b1, 1'b1, 1'b0);
    chk("t3_drained", exp_q.size(), 0);
    cycle(1'b0, 1'b1, 1'b0);
    check_cnts("t3");
    chk("t3_err_cnt_1", err_cnt, 1);
    cycle(1'b0, 1'b0, 1'b1);

    // Empty FIFO with en held high
    begin
      int rd_seen = 0, v_seen = 0;
      for (int i = 0; i < 20; i++) begin
        cycle(1'b1, 1'b1, 1'b0);
        if (fifo_rd_en) rd_seen++;
        if (m_valid) v_seen++;
      end
      chk("t4_no_rd_en", rd_seen, 0);
      chk("t4_no_valid", v_seen, 0);
      chk("t4_proto_err", proto_err, 0);
      chk("t4_busy", busy, 1);
    end
    @(posedge clk); #1 uf_inj = 1'b1;
    @(posedge clk); #1 uf_inj = 1'b0;
    chk("t4_uf_set", proto_err, 1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("t4_uf_sticky", proto_err, 1);

    // en falls with two reads outstanding
    load(8'h11, 1'b0); load(8'h22, 1'b0); load(8'h33, 1'b0);
    load_done();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t5_drain_state", dut.state_q, ST_DRAIN);
    chk("t5_drain_busy", busy, 1);
    for (int i = 0; i < 10 && dut.state_q != ST_IDLE; i++) cycle(1'b0, 1'b1, 1'b0);
    chk("t5_idle_state", dut.state_q, ST_IDLE);
    chk("t5_idle_busy", busy, 0);
    chk("t5_left_expected", exp_q.size(), 1);
    chk("t5_left_in_fifo", fq.size(), 1);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) load(vals[i], 1'b0);
    load_done();
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    chk("t6_m_valid", m_valid, 0);
    chk("t6_word_cnt", word_cnt, 0);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_proto_err", proto_err, 0);
    chk("t6_busy", busy, 0);
    chk("t6_lost_words", lost, 2);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b1, 1'b1, 1'b0);
    chk("t6_drained", exp_q.size(), 0);
    cycle(1'b0, 1'b1, 1'b0);
    check_cnts("t6");
    chk("t6_word_cnt_3", word_cnt, 3);
    chk("lockstep_dut2", lockstep_bad, 0);
    chk("occ_bound_all", occ_bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
